// File: rtl/period_capture_pkg.sv
// period_capture_pkg
//   Shared types and helpers for the period_capture_array slice.
//   - state_e      : readout FSM states.
//   - rec_field_e  : record fields, listed in transmit order (MSB first).
//   - rec_w()      : record width for a given counter width.
//   - field_lsb()  : bit position of each field's LSB inside a record.
//   Build option: define PERIOD_CAPTURE_DUTY_EN to append TIME_HIGH to every
//   record (REC_W = 2*COUNTER_BITS+2); otherwise REC_W = COUNTER_BITS+2.
package period_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef PERIOD_CAPTURE_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  // Record layout, most significant field first:
  //   {VALID, OVF, PERIOD[COUNTER_BITS-1:0] (, TIME_HIGH[COUNTER_BITS-1:0])}
  typedef enum int {
    REC_VALID     = 0,
    REC_OVF       = 1,
    REC_PERIOD    = 2,
    REC_TIME_HIGH = 3
  } rec_field_e;

  function automatic int rec_w(input int counter_bits);
    return DUTY_EN ? (2 * counter_bits + 2) : (counter_bits + 2);
  endfunction

  function automatic int field_lsb(input rec_field_e field, input int counter_bits);
    int pos;
    case (field)
      REC_VALID:  pos = rec_w(counter_bits) - 1;
      REC_OVF:    pos = rec_w(counter_bits) - 2;
      REC_PERIOD: pos = DUTY_EN ? counter_bits : 0;
      default:    pos = 0;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/period_capture_channel.sv
// period_capture_channel
//   One measurement channel: input synchroniser, rising-edge detect,
//   saturating high/low phase counters, PERIOD (and optionally TIME_HIGH)
//   latches, VALID/OVF flags and stuck-input detection.
//   Ports:
//     clk      in   clock, rising edge
//     srst     in   synchronous reset, active-high
//     freq_in  in   asynchronous square-wave input
//     rec      out  packed record, layout given by period_capture_pkg
//   Build option: PERIOD_CAPTURE_DUTY_EN keeps the TIME_HIGH latch and adds
//   it to the record.
module period_capture_channel
  import period_capture_pkg::*;
#(
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int REC_W        = rec_w(COUNTER_BITS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             freq_in,
  output logic [REC_W-1:0] rec
);

  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);
  localparam int VALID_POS  = field_lsb(REC_VALID, COUNTER_BITS);
  localparam int OVF_POS    = field_lsb(REC_OVF, COUNTER_BITS);
  localparam int PERIOD_LSB = field_lsb(REC_PERIOD, COUNTER_BITS);

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    prev_reg;
  logic                    armed_reg;
  logic [COUNTER_BITS-1:0] high_cnt_reg;
  logic [COUNTER_BITS-1:0] low_cnt_reg;
  logic [COUNTER_BITS-1:0] period_reg;
  logic                    valid_reg;
  logic                    ovf_reg;

  logic                    synced;
  logic                    rise;
  logic                    high_sat;
  logic                    low_sat;
  logic [COUNTER_BITS:0]   phase_sum;
  logic [COUNTER_BITS-1:0] period_next;
  logic                    latch_en;

  assign synced      = sync_reg[SYNC_STAGES-1];
  assign rise        = synced & ~prev_reg;
  assign high_sat    = (high_cnt_reg == CNT_MAX);
  assign low_sat     = (low_cnt_reg == CNT_MAX);
  // One extra bit so the sum of two saturated counters cannot wrap.
  assign phase_sum   = {1'b0, high_cnt_reg} + {1'b0, low_cnt_reg};
  assign period_next = phase_sum[COUNTER_BITS] ? CNT_MAX : phase_sum[COUNTER_BITS-1:0];
  // The first rising edge after reset only arms the channel.
  assign latch_en    = rise & armed_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], freq_in};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      high_cnt_reg <= '0;
      low_cnt_reg  <= '0;
      period_reg   <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      prev_reg <= synced;

      // The rise cycle itself is the first cycle of the new high phase.
      if (rise) begin
        armed_reg    <= 1'b1;
        high_cnt_reg <= CNT_ONE;
        low_cnt_reg  <= '0;
      end else if (synced) begin
        if (!high_sat) high_cnt_reg <= high_cnt_reg + CNT_ONE;
      end else begin
        if (!low_sat) low_cnt_reg <= low_cnt_reg + CNT_ONE;
      end

      // A fresh measurement takes priority over the stuck indication;
      // it still reports OVF if one of its phases saturated.
      if (latch_en) begin
        period_reg <= period_next;
        valid_reg  <= 1'b1;
        ovf_reg    <= high_sat | low_sat;
      end else if (high_sat | low_sat) begin
        valid_reg <= 1'b0;
        ovf_reg   <= 1'b1;
      end
    end
  end

`ifdef PERIOD_CAPTURE_DUTY_EN
  logic [COUNTER_BITS-1:0] time_high_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      time_high_reg <= '0;
    end else if (latch_en) begin
      time_high_reg <= high_cnt_reg;
    end
  end
`endif

  always_comb begin
    rec                                 = '0;
    rec[VALID_POS]                      = valid_reg;
    rec[OVF_POS]                        = ovf_reg;
    rec[PERIOD_LSB +: COUNTER_BITS]     = period_reg;
`ifdef PERIOD_CAPTURE_DUTY_EN
    rec[field_lsb(REC_TIME_HIGH, COUNTER_BITS) +: COUNTER_BITS] = time_high_reg;
`endif
  end

endmodule

// File: rtl/period_capture_array.sv
// period_capture_array
//   CHANNELS independent period/duty measurement channels plus a serial
//   readout that streams a coherent snapshot of every channel's record,
//   channel 0 first, each record MSB first, with valid/ready handshaking.
//   Ports:
//     CLK         in   clock, rising edge
//     RST         in   synchronous reset, active-high
//     FREQ_IN     in   [CHANNELS] asynchronous inputs, bit i = channel i
//     CAPTURE     in   one-cycle snapshot request (ignored while streaming)
//     BUSY        out  a frame is being streamed
//     SOUT_DATA   out  serial readout bit
//     SOUT_VALID  out  SOUT_DATA is valid
//     SOUT_READY  in   sink accepts the bit when high with SOUT_VALID
//     SOUT_LAST   out  final bit of the frame
//   Build option: PERIOD_CAPTURE_DUTY_EN adds TIME_HIGH to each record.
module period_capture_array
  import period_capture_pkg::*;
#(
  parameter int CHANNELS     = 8,
  parameter int COUNTER_BITS = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] FREQ_IN,
  input  logic                CAPTURE,
  output logic                BUSY,
  output logic                SOUT_DATA,
  output logic                SOUT_VALID,
  input  logic                SOUT_READY,
  output logic                SOUT_LAST
);

  localparam int REC_W   = rec_w(COUNTER_BITS);
  localparam int FRAME_W = CHANNELS * REC_W;
  localparam int IDX_W   = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [REC_W-1:0]   rec_bus [CHANNELS];
  logic [FRAME_W-1:0] frame_bus;

  logic [FRAME_W-1:0] shadow_reg;
  logic [IDX_W-1:0]   idx_reg;
  state_e             state_reg;
  state_e             state_next;

  logic               capture_accept;
  logic               bit_accept;
  logic               last_bit;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    period_capture_channel #(
      .COUNTER_BITS (COUNTER_BITS),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_chan (
      .clk     (CLK),
      .srst    (RST),
      .freq_in (FREQ_IN[gi]),
      .rec     (rec_bus[gi])
    );

    // Channel 0 occupies the top of the frame so it leaves first.
    assign frame_bus[FRAME_W-1-gi*REC_W -: REC_W] = rec_bus[gi];
  end

  assign capture_accept = (state_reg == IDLE) & CAPTURE;
  assign bit_accept     = (state_reg == SHIFT) & SOUT_READY;
  assign last_bit       = (idx_reg == IDX_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (CAPTURE) state_next = SHIFT;
      SHIFT:   if (SOUT_READY && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: everything is decoded from registers, so outputs only
  // change on clock edges and hold steady while the sink stalls.
  always_comb begin
    SOUT_VALID = 1'b0;
    BUSY       = 1'b0;
    SOUT_DATA  = 1'b0;
    SOUT_LAST  = 1'b0;
    if (state_reg == SHIFT) begin
      SOUT_VALID = 1'b1;
      BUSY       = 1'b1;
      SOUT_DATA  = shadow_reg[FRAME_W-1];
      SOUT_LAST  = last_bit;
    end
  end

  // Snapshot shift register and bit index. The shadow is loaded from the
  // channel registers as they stand before the capture edge, so a latch on
  // that same edge lands in the next frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_reg <= '0;
      idx_reg    <= '0;
    end else if (capture_accept) begin
      shadow_reg <= frame_bus;
      idx_reg    <= '0;
    end else if (bit_accept) begin
      shadow_reg <= {shadow_reg[FRAME_W-2:0], 1'b0};
      idx_reg    <= idx_reg + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_period_capture_array.sv
module tb_period_capture_array;

  localparam int CH   = 4;
  localparam int CB   = 8;
  localparam int S    = 2;
  localparam int MAXV = 255;
`ifdef PERIOD_CAPTURE_DUTY_EN
  localparam int REC_W = 2 * CB + 2;
  localparam logic [REC_W-1:0] EXP_B_REC0 = {1'b1, 1'b0, 8'h0A, 8'h04};
  localparam logic [REC_W-1:0] EXP_C_REC1 = {1'b0, 1'b1, 8'h06, 8'h03};
  localparam logic [REC_W-1:0] EXP_C_REC3 = {1'b0, 1'b1, 8'h00, 8'h00};
`else
  localparam int REC_W = CB + 2;
  localparam logic [REC_W-1:0] EXP_B_REC0 = {1'b1, 1'b0, 8'h0A};
  localparam logic [REC_W-1:0] EXP_C_REC1 = {1'b0, 1'b1, 8'h06};
  localparam logic [REC_W-1:0] EXP_C_REC3 = {1'b0, 1'b1, 8'h00};
`endif
  localparam int FRAME_BITS = CH * REC_W;
  localparam int HIST_MAX   = 65535;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          capture    = 1'b0;
  logic          sout_ready = 1'b1;
  logic [CH-1:0] freq_in    = '0;
  logic          busy, sout_data, sout_valid, sout_last;

  period_capture_array #(
    .CHANNELS     (CH),
    .COUNTER_BITS (CB),
    .SYNC_STAGES  (S)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .FREQ_IN    (freq_in),
    .CAPTURE    (capture),
    .BUSY       (busy),
    .SOUT_DATA  (sout_data),
    .SOUT_VALID (sout_valid),
    .SOUT_READY (sout_ready),
    .SOUT_LAST  (sout_last)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus configuration: cfg_p == 0 holds cfg_lvl, else square wave.
  int   cfg_p [CH] = '{default: 0};
  int   cfg_h [CH] = '{default: 0};
  int   ph    [CH] = '{default: 0};
  logic cfg_lvl [CH] = '{default: 1'b0};
  int   ready_mode = 0;

  // Reference model state
  int            edge_cnt   = 0;
  int            last_reset = 0;
  logic [CH-1:0] in_hist [0:HIST_MAX];
  bit            model_busy = 1'b0;
  int            bits_left  = 0;
  int            frames_done = 0;

  typedef struct packed {
    logic data;
    logic last;
  } exp_bit_t;
  exp_bit_t exp_q[$];
  logic     rx_bits[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Synchronised level of a channel during the cycle following edge c:
  // the input sampled S-1 edges earlier, or 0 while the synchroniser is
  // still refilling after reset.
  function automatic logic level(input int ch, input int c);
    if (c < last_reset + S) return 1'b0;
    return in_hist[c-S+1][ch];
  endfunction

  // Expected record for a capture sampled at edge k: replay the level
  // history since reset through the measurement rules. Edge k-1 is the
  // last edge whose effects the snapshot sees; it acted on cycle k-2.
  function automatic logic [REC_W-1:0] expect_rec(input int ch, input int k);
    int   hi, lo, period, th;
    bit   valid, ovf, armed, stuck;
    logic l, p;
    logic [REC_W-1:0] r;
    hi = 0; lo = 0; period = 0; th = 0;
    valid = 0; ovf = 0; armed = 0;
    for (int c = last_reset; c <= k - 2; c++) begin
      l = level(ch, c);
      p = (c == last_reset) ? 1'b0 : level(ch, c - 1);
      stuck = (hi >= MAXV) || (lo >= MAXV);
      if (stuck) begin
        valid = 0;
        ovf   = 1;
      end
      if (l && !p) begin
        if (armed) begin
          period = (hi + lo > MAXV) ? MAXV : hi + lo;
          th     = (hi > MAXV) ? MAXV : hi;
          valid  = 1;
          ovf    = stuck;
        end
        armed = 1;
        hi = 1;
        lo = 0;
      end else if (l) begin
        hi++;
      end else begin
        lo++;
      end
    end
`ifdef PERIOD_CAPTURE_DUTY_EN
    r = {valid, ovf, period[CB-1:0], th[CB-1:0]};
`else
    r = {valid, ovf, period[CB-1:0]};
`endif
    return r;
  endfunction

  // Model: tracks accepted captures and handshakes, pushes expected frames.
  always @(posedge clk) begin
    logic [REC_W-1:0] r;
    edge_cnt++;
    if (edge_cnt <= HIST_MAX) in_hist[edge_cnt] = freq_in;
    if (rst) begin
      last_reset = edge_cnt;
      model_busy = 1'b0;
      bits_left  = 0;
      exp_q.delete();
    end else if (model_busy) begin
      if (sout_ready) begin
        bits_left--;
        if (bits_left == 0) model_busy = 1'b0;
      end
    end else if (capture) begin
      for (int ch = 0; ch < CH; ch++) begin
        r = expect_rec(ch, edge_cnt);
        for (int i = REC_W - 1; i >= 0; i--) begin
          exp_q.push_back('{data: r[i], last: (ch == CH - 1) && (i == 0)});
        end
      end
      model_busy = 1'b1;
      bits_left  = FRAME_BITS;
      $display("capture accepted at edge %0d, expecting %0d bits", edge_cnt, FRAME_BITS);
    end
  end

  // Monitor: compares DUT outputs against the model on the falling edge.
  always @(negedge clk) begin
    exp_bit_t b;
    check("busy", busy, model_busy);
    check("sout_valid", sout_valid, model_busy);
    if (!model_busy) begin
      check("idle_data", sout_data, 1'b0);
      check("idle_last", sout_last, 1'b0);
    end else if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got valid bit expected none (edge %0d)", edge_cnt);
    end else begin
      check("sout_data", sout_data, exp_q[0].data);
      check("sout_last", sout_last, exp_q[0].last);
      if (sout_ready) begin
        b = exp_q.pop_front();
        rx_bits.push_back(sout_data);
        if (b.last) frames_done++;
      end
    end
  end

  // Input driver
  always @(posedge clk) begin
    #1;
    for (int ch = 0; ch < CH; ch++) begin
      if (cfg_p[ch] == 0) begin
        freq_in[ch] = cfg_lvl[ch];
      end else begin
        freq_in[ch] = (ph[ch] < cfg_h[ch]);
        ph[ch] = (ph[ch] + 1) % cfg_p[ch];
      end
    end
    case (ready_mode)
      0:       sout_ready = 1'b1;
      1:       sout_ready = ~sout_ready;
      default: sout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_sq(input int ch, input int p, input int h);
    cfg_p[ch] = p;
    cfg_h[ch] = h;
    ph[ch]    = 0;
  endtask

  task automatic set_hold(input int ch, input logic lvl);
    cfg_p[ch]   = 0;
    cfg_lvl[ch] = lvl;
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    step(1);
    capture = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (model_busy && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (model_busy) begin
      failures++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", bound);
    end
    step(1);
  endtask

  function automatic logic [REC_W-1:0] get_rec(input int ch);
    logic [REC_W-1:0] r = '0;
    if (rx_bits.size() >= FRAME_BITS) begin
      for (int i = 0; i < REC_W; i++) r = {r[REC_W-2:0], rx_bits[ch*REC_W+i]};
    end
    return r;
  endfunction

  initial begin
    int fd, n;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    // Capture straight after reset: all-zero frame.
    rx_bits.delete();
    pulse_capture();
    wait_idle(200);
    check("reset_frame_len", rx_bits.size(), FRAME_BITS);
    check("reset_frame_rec0", get_rec(0), '0);

    // Known square waves.
    set_sq(0, 10, 4);
    set_sq(1, 6, 3);
    set_sq(2, 13, 5);
    step(60);
    rx_bits.delete();
    pulse_capture();
    wait_idle(200);
    check("sq_rec0", get_rec(0), EXP_B_REC0);

    // ch1 stuck low: VALID drops, OVF set, PERIOD held.
    set_hold(1, 1'b0);
    step(300);
    rx_bits.delete();
    pulse_capture();
    wait_idle(200);
    check("stuck_rec1", get_rec(1), EXP_C_REC1);
    check("never_armed_rec3", get_rec(3), EXP_C_REC3);

    // Backpressure: READY toggles every cycle.
    ready_mode = 1;
    rx_bits.delete();
    pulse_capture();
    wait_idle(400);
    check("bp_frame_len", rx_bits.size(), FRAME_BITS);
    ready_mode = 0;

    // Second CAPTURE while busy is ignored.
    fd = frames_done;
    pulse_capture();
    step(5);
    pulse_capture();
    wait_idle(200);
    check("one_frame_per_busy", frames_done - fd, 1);

    // Sweep capture phase against ch2 latches.
    for (int off = 0; off < 13; off++) begin
      step(off);
      pulse_capture();
      wait_idle(200);
    end

    // Reset after 7 accepted bits aborts the frame.
    pulse_capture();
    n = 0;
    while (bits_left > FRAME_BITS - 7 && n < 200) begin
      step(1);
      n++;
    end
    check("abort_point_reached", (bits_left <= FRAME_BITS - 7), 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    rx_bits.delete();
    pulse_capture();
    wait_idle(200);
    check("post_abort_frame_len", rx_bits.size(), FRAME_BITS);

    // Randomised rounds.
    for (int r = 0; r < 20; r++) begin
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 4) == 0) begin
          set_hold(ch, 1'($urandom_range(0, 1)));
        end else begin
          n = $urandom_range(4, 40);
          set_sq(ch, n, $urandom_range(1, n - 1));
        end
      end
      ready_mode = $urandom_range(0, 2);
      step($urandom_range(0, 300));
      pulse_capture();
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(1, 30));
        pulse_capture();
      end
      wait_idle(2000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
